// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative signed/unsigned multiply/divide unit for the EX stage
//
// One bit per cycle: shift-add multiply or restoring divide over operand
// magnitudes, then a single sign-correction cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous reset, active low
//   op     000 none, 001 MULTU, 010 MULT, 011 DIVU, 100 DIV, others none
//   a, b   multiplicand/dividend, multiplier/divisor
//   flush  abort the operation in flight (also blocks a start in IDLE)
//   hi/lo  product upper/lower half, or remainder/quotient
//   done   unit idle and able to accept an op
//   valid  one-cycle pulse when hi/lo have just been updated
module ex_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             valid
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    // acc: upper product half / partial remainder; q: multiplier shifting
    // out / dividend shifting out while quotient bits shift in; m: the other
    // operand magnitude (multiplicand or divisor).
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;

    logic             op_mul, op_div, op_signed, start;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] acc_nxt, q_nxt;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        op_mul    = (op == 3'b001) || (op == 3'b010);
        op_div    = (op == 3'b011) || (op == 3'b100);
        op_signed = (op == 3'b010) || (op == 3'b100);
        start     = (op_mul || op_div) && !flush;
        a_neg     = op_signed && a[WIDTH-1];
        b_neg     = op_signed && b[WIDTH-1];
        // Negating MIN gives MIN, which read unsigned is the right magnitude.
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc} + {1'b0, (q[0] ? m : '0)};
        div_shift = {acc, q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m};
        if (is_div) begin
            // Restoring step: keep the difference only when it did not borrow.
            acc_nxt = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            acc_nxt = mul_sum[WIDTH:1];
            q_nxt   = {mul_sum[0], q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = neg_res ? -{acc, q} : {acc, q};
        quo_fix  = neg_res ? -q : q;
        rem_fix  = neg_rem ? -acc : acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b1;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CALC;
                        done    <= 1'b0;
                        cnt     <= CW'(WIDTH);
                        acc     <= '0;
                        q       <= op_div ? mag_a : mag_b;
                        m       <= op_div ? mag_b : mag_a;
                        is_div  <= op_div;
                        // Divide by zero leaves an all-ones quotient that
                        // must not be negated; the remainder comes out as
                        // |a| and re-signs back to the raw dividend.
                        neg_res <= (a_neg ^ b_neg) && !(op_div && (b == '0));
                        neg_rem <= op_div && a_neg;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        acc <= acc_nxt;
                        q   <= q_nxt;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (!flush) begin
                        valid <= 1'b1;
                        hi    <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                        lo    <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            endcase
        end
    end

endmodule
